spi_settings_target: RTL

// - SPI target (slave) bridge: the far end of the radio-core SPI master (sen/sclk/mosi/miso).
// - Decodes SPI frames into settings-bus writes and readback-bus reads.
// - Used where an external/host SPI master must reach a register file on bus_clk:
//   - a board controller;
//   - a bench model of the codec SPI port.
// - SPI mode 0, MSB first, active-low sen.
// - SPI pins are oversampled by bus_clk; there is no second clock domain.

---
 rtl/spi_settings_target.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/spi_settings_target.sv
// SPI mode-0 target bridging 48-bit frames onto settings-write / readback-read strobes.
// SPI pins oversampled on bus_clk; set_stb one cycle after rising edge 48; no backpressure (fixed SCLK minimum period).
module spi_settings_target #(
  parameter int SYNC_STAGES = 2,
  parameter int RB_LATENCY  = 2
) (
  input  logic        bus_clk,
  input  logic        bus_rst_n,
  input  logic        spi_sen,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        miso_oe,
  output logic        set_stb,
  output logic [7:0]  set_addr,
  output logic [31:0] set_data,
  output logic        rb_stb,
  output logic [7:0]  rb_addr,
  input  logic [31:0] rb_data,
  output logic        frame_err,
  output logic        busy
);

  typedef enum logic [2:0] {
    WAIT_DESEL,
    IDLE,
    CMD,
    RD_WAIT,
    DATA,
    DONE
  } state_t;

  localparam logic [1:0] LAT = 2'(RB_LATENCY);

  logic [SYNC_STAGES-1:0] sen_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_d;
  logic                   sen_s;
  logic                   sclk_s;
  logic                   mosi_s;
  logic                   sclk_rise;
  logic                   sclk_fall;

  state_t      state;
  logic [5:0]  bit_cnt;
  logic [14:0] cmd_sr;
  logic [30:0] data_sr;
  logic [31:0] tx_sr;
  logic        rw;
  logic [7:0]  addr_q;
  logic [1:0]  wait_cnt;

  assign sen_s     = sen_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      sen_sync  <= '0;
      sclk_sync <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
    end else begin
      sen_sync  <= {sen_sync[SYNC_STAGES-2:0], spi_sen};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_d    <= sclk_s;
    end
  end

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      state     <= WAIT_DESEL;
      bit_cnt   <= '0;
      cmd_sr    <= '0;
      data_sr   <= '0;
      tx_sr     <= '0;
      rw        <= 1'b0;
      addr_q    <= '0;
      wait_cnt  <= '0;
      spi_miso  <= 1'b0;
      set_stb   <= 1'b0;
      set_addr  <= '0;
      set_data  <= '0;
      rb_stb    <= 1'b0;
      rb_addr   <= '0;
      frame_err <= 1'b0;
    end else begin
      set_stb   <= 1'b0;
      rb_stb    <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        WAIT_DESEL: begin
          // A frame already running at reset release is skipped entirely.
          if (sen_s) state <= IDLE;
        end
        IDLE: begin
          spi_miso <= 1'b0;
          if (!sen_s) begin
            state   <= CMD;
            bit_cnt <= '0;
            cmd_sr  <= '0;
          end
        end
        CMD: begin
          if (sen_s) begin
            state     <= IDLE;
            frame_err <= 1'b1;
            spi_miso  <= 1'b0;
          end else if (sclk_rise) begin
            cmd_sr  <= {cmd_sr[13:0], mosi_s};
            bit_cnt <= bit_cnt + 6'd1;
            if (bit_cnt == 6'd15) begin
              rw      <= cmd_sr[14];
              addr_q  <= {cmd_sr[6:0], mosi_s};
              data_sr <= '0;
              if (cmd_sr[14]) begin
                rb_addr  <= {cmd_sr[6:0], mosi_s};
                rb_stb   <= 1'b1;
                wait_cnt <= '0;
                state    <= RD_WAIT;
              end else begin
                state <= DATA;
              end
            end
          end
        end
        RD_WAIT: begin
          // Finishes well before falling edge 16 given the minimum SCLK phase.
          if (sen_s) begin
            state     <= IDLE;
            frame_err <= 1'b1;
            spi_miso  <= 1'b0;
          end else if (wait_cnt == LAT) begin
            tx_sr <= rb_data;
            state <= DATA;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        DATA: begin
          // Edge 48 wins over a simultaneous deselect.
          if (sclk_rise && bit_cnt == 6'd47) begin
            bit_cnt  <= 6'd48;
            spi_miso <= 1'b0;
            state    <= DONE;
            if (!rw) begin
              set_stb  <= 1'b1;
              set_addr <= addr_q;
              set_data <= {data_sr, mosi_s};
            end
          end else if (sen_s) begin
            state     <= IDLE;
            frame_err <= 1'b1;
            spi_miso  <= 1'b0;
          end else begin
            if (sclk_rise) begin
              data_sr <= {data_sr[29:0], mosi_s};
              bit_cnt <= bit_cnt + 6'd1;
            end
            if (sclk_fall && rw) begin
              spi_miso <= tx_sr[31];
              tx_sr    <= {tx_sr[30:0], 1'b0};
            end
          end
        end
        DONE: begin
          spi_miso <= 1'b0;
          if (sen_s) state <= IDLE;
        end
        default: state <= WAIT_DESEL;
      endcase
    end
  end

  assign miso_oe = (state != WAIT_DESEL) && !sen_s;
  assign busy    = (state != IDLE) && (state != WAIT_DESEL);

endmodule
